// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

   localparam int WORD_BYTES = 8;
   localparam int WAIT_CNT_W = 4;
   localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

   // True when a byte address does not sit on a doubleword boundary.
   function automatic logic misaligned(input logic [2:0] addrLow);
      return addrLow != 3'd0;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 64 RAM: synchronous write, registered read.
// The read register is the responder's read-data output, so it is cleared
// by reset and can be loaded with zero instead of array data.
module dmem_array #(
   parameter int DEPTH_WORDS = 512,
   localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             re,
   input  logic             clearRead,
   input  logic [IDX_W-1:0] index,
   input  logic [63:0]      writeData,
   output logic [63:0]      readData
);

   logic [63:0] mem_r [DEPTH_WORDS];
   logic [63:0] readData_r;

   // Array write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[index] <= writeData;
      end
   end

   // Read register: holds until the next read, zero on reset or error.
   always_ff @(posedge clk) begin
      if (reset) begin
         readData_r <= 64'd0;
      end else if (re) begin
         readData_r <= clearRead ? 64'd0 : mem_r[index];
      end
   end

   assign readData = readData_r;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory bus responder: accepts d_MemRead/d_MemWrite, waits
// WAIT_STATES cycles, then pulses d_Ready for one cycle.
// Optional macro DMEM_ERROR_CHECK_EN enables d_Error reporting for
// misaligned, out-of-range and read+write requests.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 512,
   parameter int          WAIT_STATES = 1,
   parameter logic [63:0] ADDR_BASE   = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] d_address,
   input  logic [63:0] d_WriteData,
   input  logic        d_MemWrite,
   input  logic        d_MemRead,
   output logic [63:0] d_ReadData,
   output logic        d_Ready,
   output logic        d_Error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   state_t                state_r, nextState_s;
   logic [WAIT_CNT_W-1:0] waitCnt_r, nextWaitCnt_s;
   logic [63:0]           addr_r, wdata_r;
   op_t                   op_r;
   logic                  ready_r, error_r;

   logic                  accept_s, enterResp_s;
   logic [63:0]           effAddr_s, offset_s;
   op_t                   effOp_s;
   logic                  effErr_s, readLike_s;
   logic [IDX_W-1:0]      index_s;
   logic                  arrWe_s, arrRe_s;
   logic                  unusedBits_s;

`ifdef DMEM_ERROR_CHECK_EN
   logic                  both_r, effBoth_s;
`endif

   assign accept_s = (state_r == IDLE) && (d_MemRead || d_MemWrite);

   // Next-state and wait-counter logic.
   always_comb begin
      nextState_s   = state_r;
      nextWaitCnt_s = waitCnt_r;
      enterResp_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               nextWaitCnt_s = WAIT_LOAD;
               if (WAIT_STATES > 0) begin
                  nextState_s = WAIT;
               end else begin
                  nextState_s = RESP;
                  enterResp_s = 1'b1;
               end
            end else begin
               nextState_s = IDLE;
            end
         end
         WAIT: begin
            if (waitCnt_r == '0) begin
               nextState_s = RESP;
               enterResp_s = 1'b1;
            end else begin
               nextWaitCnt_s = waitCnt_r - 1'b1;
            end
         end
         RESP:    nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
   end

   // Request view: live bus inputs while accepting, latched copy otherwise.
   // With zero wait states the read happens on the accepting edge itself.
   always_comb begin
      if (state_r == IDLE) begin
         effAddr_s = d_address;
         effOp_s   = d_MemWrite ? OP_WRITE : OP_READ;
`ifdef DMEM_ERROR_CHECK_EN
         effBoth_s = d_MemRead && d_MemWrite;
`endif
      end else begin
         effAddr_s = addr_r;
         effOp_s   = op_r;
`ifdef DMEM_ERROR_CHECK_EN
         effBoth_s = both_r;
`endif
      end
   end

   assign offset_s = effAddr_s - ADDR_BASE;
   assign index_s  = offset_s[BYTE_SHIFT +: IDX_W];

`ifdef DMEM_ERROR_CHECK_EN
   assign effErr_s     = misaligned(effAddr_s[2:0]) ||
                         (offset_s[63:BYTE_SHIFT+IDX_W] != '0) || effBoth_s;
   assign readLike_s   = (effOp_s == OP_READ) || effBoth_s;
   assign unusedBits_s = ^offset_s[BYTE_SHIFT-1:0];
`else
   assign effErr_s     = 1'b0;
   assign readLike_s   = (effOp_s == OP_READ);
   assign unusedBits_s = ^{offset_s[BYTE_SHIFT-1:0], offset_s[63:BYTE_SHIFT+IDX_W]};
`endif

   // State, counter, request latch and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         waitCnt_r <= '0;
         addr_r    <= 64'd0;
         wdata_r   <= 64'd0;
         op_r      <= OP_READ;
         ready_r   <= 1'b0;
         error_r   <= 1'b0;
`ifdef DMEM_ERROR_CHECK_EN
         both_r    <= 1'b0;
`endif
      end else begin
         state_r   <= nextState_s;
         waitCnt_r <= nextWaitCnt_s;
         ready_r   <= enterResp_s;
         error_r   <= enterResp_s && effErr_s;
         if (accept_s) begin
            addr_r  <= d_address;
            wdata_r <= d_WriteData;
            op_r    <= effOp_s;
`ifdef DMEM_ERROR_CHECK_EN
            both_r  <= effBoth_s;
`endif
         end
      end
   end

   // Writes commit on the edge leaving RESP unless flagged or reset.
   assign arrWe_s = (state_r == RESP) && (op_r == OP_WRITE) && !error_r && !reset;
   assign arrRe_s = enterResp_s && readLike_s;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) uArray (
      .clk       (clk),
      .reset     (reset),
      .we        (arrWe_s),
      .re        (arrRe_s),
      .clearRead (effErr_s),
      .index     (index_s),
      .writeData (wdata_r),
      .readData  (d_ReadData)
   );

   assign d_Ready = ready_r;
   assign d_Error = error_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with 1, 0 and 3
// wait states; error-check expectations follow DMEM_ERROR_CHECK_EN.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] addrA [3];
   logic [63:0] wdA   [3];
   logic [63:0] rdA   [3];
   logic        rdReq [3];
   logic        wrReq [3];
   logic        rdyA  [3];
   logic        errA  [3];

   int nCompared = 0;
   int nMismatch = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.WAIT_STATES(1)) uWs1 (
      .clk(clk), .reset(reset), .d_address(addrA[0]), .d_WriteData(wdA[0]),
      .d_MemWrite(wrReq[0]), .d_MemRead(rdReq[0]), .d_ReadData(rdA[0]),
      .d_Ready(rdyA[0]), .d_Error(errA[0]));

   data_mem_responder #(.WAIT_STATES(0)) uWs0 (
      .clk(clk), .reset(reset), .d_address(addrA[1]), .d_WriteData(wdA[1]),
      .d_MemWrite(wrReq[1]), .d_MemRead(rdReq[1]), .d_ReadData(rdA[1]),
      .d_Ready(rdyA[1]), .d_Error(errA[1]));

   data_mem_responder #(.WAIT_STATES(3)) uWs3 (
      .clk(clk), .reset(reset), .d_address(addrA[2]), .d_WriteData(wdA[2]),
      .d_MemWrite(wrReq[2]), .d_MemRead(rdReq[2]), .d_ReadData(rdA[2]),
      .d_Ready(rdyA[2]), .d_Error(errA[2]));

   function automatic int wsOf(input int u);
      return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
   endfunction

   task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One transaction; strobes and bus are scrambled right after acceptance.
   task automatic access(input int u, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] wd, input string tag,
                         output logic [63:0] data, output logic err);
      int lat;
      @(negedge clk);
      addrA[u] = a; wdA[u] = wd; rdReq[u] = r; wrReq[u] = w;
      @(posedge clk); #1;
      rdReq[u] = 1'b0; wrReq[u] = 1'b0;
      addrA[u] = 64'hFFFF_FFFF_FFFF_FFF1; wdA[u] = ~wd;
      lat = 1;
      while (!rdyA[u] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checkValue({tag, "/latency"}, 64'(lat), 64'(1 + wsOf(u)));
      data = rdA[u];
      err  = errA[u];
      @(posedge clk); #1;
      checkValue({tag, "/pulse_end"}, 64'(rdyA[u]), 64'd0);
   endtask

   task automatic doWrite(input int u, input logic [63:0] a, input logic [63:0] wd,
                          input logic expErr, input string tag);
      logic [63:0] d; logic e;
      access(u, 1'b0, 1'b1, a, wd, tag, d, e);
      checkValue({tag, "/err"}, 64'(e), 64'(expErr));
   endtask

   task automatic doRead(input int u, input logic [63:0] a, input logic [63:0] expData,
                         input logic expErr, input logic chkData, input string tag);
      logic [63:0] d; logic e;
      access(u, 1'b1, 1'b0, a, 64'd0, tag, d, e);
      checkValue({tag, "/err"}, 64'(e), 64'(expErr));
      if (chkData) checkValue({tag, "/data"}, d, expData);
   endtask

   initial begin
      logic [63:0] d;
      logic        e;
      int          pulses;
      for (int i = 0; i < 3; i++) begin
         addrA[i] = 64'd0; wdA[i] = 64'd0; rdReq[i] = 1'b0; wrReq[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checkValue("reset/ready", 64'(rdyA[i]), 64'd0);
         checkValue("reset/error", 64'(errA[i]), 64'd0);
         checkValue("reset/rdata", rdA[i], 64'd0);
      end
      @(negedge clk); reset = 1'b0;

      // Basic write/read with one wait state.
      doWrite(0, 64'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, "ws1_wr40");
      doRead (0, 64'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, "ws1_rd40");

      // Zero wait states: preload then back-to-back reads.
      doWrite(1, 64'h00, 64'd1, 1'b0, "ws0_wr00");
      doWrite(1, 64'h08, 64'd2, 1'b0, "ws0_wr08");
      @(negedge clk); addrA[1] = 64'h00; rdReq[1] = 1'b1;
      @(posedge clk); #1;
      checkValue("b2b/ready1", 64'(rdyA[1]), 64'd1);
      checkValue("b2b/data1", rdA[1], 64'd1);
      addrA[1] = 64'h08;
      @(posedge clk); #1;
      checkValue("b2b/gap", 64'(rdyA[1]), 64'd0);
      @(posedge clk); #1;
      checkValue("b2b/ready2", 64'(rdyA[1]), 64'd1);
      checkValue("b2b/data2", rdA[1], 64'd2);
      rdReq[1] = 1'b0;
      @(posedge clk); #1;
      checkValue("b2b/end", 64'(rdyA[1]), 64'd0);

      // Both strobes high.
      doWrite(0, 64'h10, 64'h1111_1111_1111_1111, 1'b0, "ws1_wr10");
      access(0, 1'b1, 1'b1, 64'h10, 64'h2222_2222_2222_2222, "both10", d, e);
`ifdef DMEM_ERROR_CHECK_EN
      checkValue("both10/err", 64'(e), 64'd1);
      doRead(0, 64'h10, 64'h1111_1111_1111_1111, 1'b0, 1'b1, "both10_rd");
`else
      checkValue("both10/err", 64'(e), 64'd0);
      doRead(0, 64'h10, 64'h2222_2222_2222_2222, 1'b0, 1'b1, "both10_rd");
`endif

      // Misaligned write and out-of-range read.
`ifdef DMEM_ERROR_CHECK_EN
      doWrite(0, 64'h44, 64'h0000_0000_0000_0BAD, 1'b1, "mis44");
      doRead (0, 64'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, "mis44_rd40");
      doRead (0, 64'h1000, 64'd0, 1'b1, 1'b1, "oor1000");
`else
      doWrite(0, 64'h44, 64'h0000_0000_0000_0BAD, 1'b0, "mis44");
      doRead (0, 64'h40, 64'h0000_0000_0000_0BAD, 1'b0, 1'b1, "mis44_rd40");
      doRead (0, 64'h1000, 64'd0, 1'b0, 1'b0, "oor1000");
`endif

      // Reset during WAIT of a write discards it.
      doWrite(2, 64'h18, 64'h0123_4567_89AB_CDEF, 1'b0, "ws3_wr18");
      doRead (2, 64'h18, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, "ws3_rd18");
      @(negedge clk);
      addrA[2] = 64'h18; wdA[2] = 64'hFFFF_0000_FFFF_0000; wrReq[2] = 1'b1;
      @(posedge clk); #1;
      wrReq[2] = 1'b0;
      @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checkValue("rstwait/ready", 64'(rdyA[2]), 64'd0);
      checkValue("rstwait/error", 64'(errA[2]), 64'd0);
      checkValue("rstwait/rdata", rdA[2], 64'd0);
      @(negedge clk); reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rdyA[2]) pulses++;
      end
      checkValue("rstwait/no_pulse", 64'(pulses), 64'd0);
      doRead(2, 64'h18, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, "rstwait_rd18");

      // Read data held after the pulse and across a write.
      repeat (3) @(posedge clk);
      #1;
      checkValue("hold/idle", rdA[2], 64'h0123_4567_89AB_CDEF);
      doWrite(2, 64'h20, 64'h5555_AAAA_5555_AAAA, 1'b0, "ws3_wr20");
      checkValue("hold/after_wr", rdA[2], 64'h0123_4567_89AB_CDEF);
      doRead(2, 64'h20, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b1, "ws3_rd20");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
